// File: rtl/udp_rxbuf_writer_if.sv
// Payload stream (parser -> writer) and RX buffer port (writer -> application) bundle.
// slave: the writer side; master: parser/application side.
`ifndef UDP_RXBUF_AWIDTH
`define UDP_RXBUF_AWIDTH 6
`endif

interface udp_rxbuf_writer_if #(
    parameter int unsigned AWIDTH = `UDP_RXBUF_AWIDTH
) ();
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              in_first;
    logic              in_last;
    logic              in_zlp;
    logic              in_err;
    logic [31:0]       in_src_ip;
    logic [15:0]       in_src_port;
    logic [15:0]       in_dst_port;
    logic [15:0]       in_udp_len;
    logic [AWIDTH-1:0] udp_rxbuf_addr;
    logic              udp_rxbuf_ce;
    logic              udp_rxbuf_we;
    logic [31:0]       udp_rxbuf_wdata;
    logic              udp_rxbuf_grant;
    logic              udp_rxbuf_rel;

    modport master (
        output in_valid, in_data, in_first, in_last, in_zlp, in_err,
               in_src_ip, in_src_port, in_dst_port, in_udp_len, udp_rxbuf_rel,
        input  in_ready, udp_rxbuf_addr, udp_rxbuf_ce, udp_rxbuf_we, udp_rxbuf_wdata,
               udp_rxbuf_grant
    );

    modport slave (
        input  in_valid, in_data, in_first, in_last, in_zlp, in_err,
               in_src_ip, in_src_port, in_dst_port, in_udp_len, udp_rxbuf_rel,
        output in_ready, udp_rxbuf_addr, udp_rxbuf_ce, udp_rxbuf_we, udp_rxbuf_wdata,
               udp_rxbuf_grant
    );
endinterface

// File: rtl/udp_rxbuf_writer.sv
// Packs the UDP payload byte stream into the 32-bit RX buffer (payload from word2, header last)
// and hands it to the application. Optional destination-port filter: UDP_RXBUF_PORT_FILTER_EN.
`ifndef UDP_RXBUF_AWIDTH
`define UDP_RXBUF_AWIDTH 6
`endif

module udp_rxbuf_writer #(
    parameter int unsigned AWIDTH = `UDP_RXBUF_AWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       rx_udp_port,
    udp_rxbuf_writer_if.slave bus
);
    localparam int unsigned CntW = AWIDTH + 2;
    localparam logic [CntW-1:0] MaxBytes = CntW'((2 ** AWIDTH - 2) * 4);

    typedef enum logic [2:0] {
        StIdle, StRecv, StDrop, StWrIp, StWrLen, StGrant
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       src_ip_q, src_ip_d;
    logic [15:0]       src_port_q, src_port_d;
    logic [15:0]       udp_len_q, udp_len_d;
    logic [31:0]       acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              grant_q, grant_d;

    logic              ready;
    logic              beat;
    logic              take;
    logic              port_bad;
    logic              has_byte;
    logic              word_done;
    logic              drop;
    logic [CntW-1:0]   cnt_base;
    logic [31:0]       acc_base;
    logic [31:0]       acc_new;
    logic [1:0]        lane;
    logic [AWIDTH-1:0] waddr;

`ifdef UDP_RXBUF_PORT_FILTER_EN
    assign port_bad = bus.in_dst_port != rx_udp_port;
`else
    logic unused_port;
    assign port_bad    = 1'b0;
    assign unused_port = ^{rx_udp_port, bus.in_dst_port};
`endif

    // GRANT is entered one cycle before grant_q rises; keep the stream stalled until then.
    assign ready = (state_q != StWrIp) && (state_q != StWrLen) &&
                   !((state_q == StGrant) && !grant_q);
    assign beat  = bus.in_valid && ready;

    always_comb begin
        take = beat && ((bus.in_first && ((state_q == StIdle) || (state_q == StRecv) ||
                                          (state_q == StDrop))) ||
                        (!bus.in_first && (state_q == StRecv)));

        cnt_base  = bus.in_first ? '0 : cnt_q;
        acc_base  = bus.in_first ? '0 : acc_q;
        lane      = cnt_base[1:0];
        has_byte  = !(bus.in_first && bus.in_last && bus.in_zlp);
        acc_new   = acc_base | ({24'd0, bus.in_data} << {lane, 3'b000});
        word_done = has_byte && ((lane == 2'd3) || bus.in_last);
        drop      = (bus.in_first && port_bad) ||
                    (has_byte && (cnt_base == MaxBytes)) ||
                    (bus.in_last && bus.in_err);
        waddr     = cnt_base[CntW-1:2] + AWIDTH'(2);
    end

    always_comb begin
        state_d    = state_q;
        src_ip_d   = src_ip_q;
        src_port_d = src_port_q;
        udp_len_d  = udp_len_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;

        case (state_q)
            StIdle, StRecv, StDrop: begin
                if (take) begin
                    if (bus.in_first) begin
                        src_ip_d   = bus.in_src_ip;
                        src_port_d = bus.in_src_port;
                        udp_len_d  = bus.in_udp_len;
                    end
                    if (drop) begin
                        state_d = bus.in_last ? StIdle : StDrop;
                    end else begin
                        if (word_done) begin
                            we_d    = 1'b1;
                            addr_d  = waddr;
                            wdata_d = acc_new;
                        end
                        acc_d   = (lane == 2'd3) ? '0 : acc_new;
                        cnt_d   = has_byte ? cnt_base + CntW'(1) : cnt_base;
                        state_d = bus.in_last ? StWrIp : StRecv;
                    end
                end else if (beat && (state_q == StDrop) && bus.in_last) begin
                    state_d = StIdle;
                end
            end
            StWrIp: begin
                we_d    = 1'b1;
                addr_d  = AWIDTH'(0);
                wdata_d = src_ip_q;
                state_d = StWrLen;
            end
            StWrLen: begin
                we_d    = 1'b1;
                addr_d  = AWIDTH'(1);
                wdata_d = {udp_len_q, src_port_q};
                state_d = StGrant;
            end
            StGrant: begin
                if (grant_q && bus.udp_rxbuf_rel) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        grant_d = (state_q == StGrant) && (state_d == StGrant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            src_ip_q   <= '0;
            src_port_q <= '0;
            udp_len_q  <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            grant_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_ip_q   <= src_ip_d;
            src_port_q <= src_port_d;
            udp_len_q  <= udp_len_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            grant_q    <= grant_d;
        end
    end

    assign bus.in_ready        = ready;
    assign bus.udp_rxbuf_addr  = addr_q;
    assign bus.udp_rxbuf_ce    = we_q;
    assign bus.udp_rxbuf_we    = we_q;
    assign bus.udp_rxbuf_wdata = wdata_q;
    assign bus.udp_rxbuf_grant = grant_q;

endmodule

// File: tb/tb_udp_rxbuf_writer.sv
// Scoreboard bench for udp_rxbuf_writer: packet-level model predicts buffer writes, grant
// window and stall window; a negedge monitor checks every cycle against those predictions.
`ifndef UDP_RXBUF_AWIDTH
`define UDP_RXBUF_AWIDTH 6
`endif

module tb_udp_rxbuf_writer;
    localparam int unsigned AW = `UDP_RXBUF_AWIDTH;
    localparam int MAX_BYTES = (2 ** AW - 2) * 4;
    localparam logic [15:0] RX_PORT = 16'd1234;
    localparam int NEVER = 32'h7fffffff;
`ifdef UDP_RXBUF_PORT_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rx_udp_port = RX_PORT;

    udp_rxbuf_writer_if #(.AWIDTH(AW)) bus ();

    udp_rxbuf_writer #(.AWIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_udp_port(rx_udp_port),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    wr_t  exp_q[$];
    logic [7:0] pl[$];
    bit   owned = 1'b0;
    int   g_on = -1;
    int   g_off = NEVER;
    int   rdy_lo = -1;
    int   rdy_hi = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pl_word(input int w, input int n);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            if (4 * w + k < n) r[8*k +: 8] = pl[4*w+k];
        end
        return r;
    endfunction

    // Monitor: every write must match the head of the expected queue, in the expected cycle.
    always @(negedge clk) begin
        wr_t  e;
        logic eg;
        logic er;
        if (rst_n) begin
            if (bus.udp_rxbuf_ce) begin
                if (exp_q.size() == 0) begin
                    check("write_strobe", 64'(bus.udp_rxbuf_ce), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("write_cycle", 64'(cyc), 64'(e.cyc));
                    check("write_addr", 64'(bus.udp_rxbuf_addr), 64'(e.addr));
                    check("write_data", 64'(bus.udp_rxbuf_wdata), 64'(e.data));
                    check("write_we", 64'(bus.udp_rxbuf_we), 64'd1);
                end
            end
            eg = (g_on >= 0) && (cyc >= g_on) && (cyc < g_off);
            er = !((cyc >= rdy_lo) && (cyc <= rdy_hi));
            check("grant", 64'(bus.udp_rxbuf_grant), 64'(eg));
            check("in_ready", 64'(bus.in_ready), 64'(er));
        end
    end

    task automatic fill_rand(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endtask

    task automatic send_pkt(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                            input logic [15:0] ulen, input bit err, input bit zlp,
                            input int stop_at, input bit gaps);
        int n;
        int beats;
        int a;
        bit dead;
        bit last;
        n     = zlp ? 0 : pl.size();
        beats = zlp ? 1 : n;
        dead  = owned || (FILTER && (dp != RX_PORT));
        for (int i = 0; i < beats; i++) begin
            if (stop_at >= 0 && i >= stop_at) break;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            last               = (i == beats - 1) && (stop_at < 0);
            bus.in_valid       = 1'b1;
            bus.in_first       = (i == 0);
            bus.in_last        = last;
            bus.in_data        = zlp ? 8'($urandom) : pl[i];
            bus.in_zlp         = (i == 0) ? zlp : 1'($urandom);
            bus.in_err         = last ? err : 1'($urandom);
            bus.in_src_ip      = (i == 0) ? ip : $urandom;
            bus.in_src_port    = (i == 0) ? sp : 16'($urandom);
            bus.in_dst_port    = (i == 0) ? dp : 16'($urandom);
            bus.in_udp_len     = (i == 0) ? ulen : 16'($urandom);
            for (int t = 0; !bus.in_ready; t++) begin
                if (t >= 20) begin
                    n_err++;
                    $display("FAIL ready_timeout: in_ready stuck 0, expected 1 within 20 cycles");
                    $fatal(1, "stream stalled");
                end
                @(negedge clk);
            end
            a = cyc;
            if ((!zlp && i >= MAX_BYTES) || (last && err)) dead = 1'b1;
            if (!zlp && !dead && ((i % 4 == 3) || last))
                exp_q.push_back('{a + 1, AW'(2 + i / 4), pl_word(i / 4, n)});
            if (last && !dead) begin
                exp_q.push_back('{a + 2, AW'(0), ip});
                exp_q.push_back('{a + 3, AW'(1), {ulen, sp}});
                g_on   = a + 4;
                g_off  = NEVER;
                owned  = 1'b1;
                rdy_lo = a + 1;
                rdy_hi = a + 3;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic release_buf(input int delay);
        for (int t = 0; cyc < g_on; t++) begin
            if (t >= 20) begin
                n_err++;
                $display("FAIL grant_wait: grant never predicted, expected by cycle %0d", g_on);
                $fatal(1, "grant wait expired");
            end
            @(negedge clk);
        end
        repeat (delay) @(negedge clk);
        @(negedge clk);
        bus.udp_rxbuf_rel = 1'b1;
        g_off = cyc + 1;
        owned = 1'b0;
        @(negedge clk);
        bus.udp_rxbuf_rel = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_addr"}, 64'(bus.udp_rxbuf_addr), 64'd0);
        check({tag, "_ce"}, 64'(bus.udp_rxbuf_ce), 64'd0);
        check({tag, "_we"}, 64'(bus.udp_rxbuf_we), 64'd0);
        check({tag, "_wdata"}, 64'(bus.udp_rxbuf_wdata), 64'd0);
        check({tag, "_grant"}, 64'(bus.udp_rxbuf_grant), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        check("pending_at_reset", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        owned  = 1'b0;
        g_on   = -1;
        rdy_lo = -1;
        rdy_hi = -1;
        @(negedge clk);
        check_zero_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        string s;
        int    n;
        bit    zlp;
        bit    err;
        logic [15:0] dp;

        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_first = 1'b0;
        bus.in_last = 1'b0;
        bus.in_zlp = 1'b0;
        bus.in_err = 1'b0;
        bus.in_src_ip = '0;
        bus.in_src_port = '0;
        bus.in_dst_port = '0;
        bus.in_udp_len = '0;
        bus.udp_rxbuf_rel = 1'b0;

        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        check("reset_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;

        // Reference packet, then a second packet while the buffer is still owned.
        s = "UDP Send Test\n";
        pl.delete();
        for (int i = 0; i < s.len(); i++) pl.push_back(s[i]);
        pl.push_back(8'h00);
        send_pkt(32'h0a01a8c0, 16'd1111, RX_PORT, 16'd23, 1'b0, 1'b0, -1, 1'b0);
        fill_rand(9);
        send_pkt($urandom, 16'd7, RX_PORT, 16'd17, 1'b0, 1'b0, -1, 1'b0);
        release_buf(2);

        // Error on the last beat, a stray rel while idle, then a good packet.
        fill_rand(10);
        send_pkt($urandom, 16'd5, RX_PORT, 16'd18, 1'b1, 1'b0, -1, 1'b0);
        @(negedge clk);
        bus.udp_rxbuf_rel = 1'b1;
        @(negedge clk);
        bus.udp_rxbuf_rel = 1'b0;
        fill_rand(6);
        send_pkt($urandom, 16'd6, RX_PORT, 16'd14, 1'b0, 1'b0, -1, 1'b1);
        release_buf(0);

        // Capacity boundary.
        fill_rand(MAX_BYTES + 1);
        send_pkt($urandom, 16'd8, RX_PORT, 16'(MAX_BYTES + 9), 1'b0, 1'b0, -1, 1'b0);
        fill_rand(MAX_BYTES);
        send_pkt($urandom, 16'd9, RX_PORT, 16'(MAX_BYTES + 8), 1'b0, 1'b0, -1, 1'b0);
        release_buf(1);

        // Zero-length payload.
        send_pkt($urandom, 16'd10, RX_PORT, 16'd8, 1'b0, 1'b1, -1, 1'b0);
        release_buf(0);

        // Foreign destination port.
        fill_rand(5);
        send_pkt($urandom, 16'd11, 16'd5000, 16'd13, 1'b0, 1'b0, -1, 1'b0);
        if (owned) release_buf(0);

        // Reset in the middle of a packet, then a clean packet.
        fill_rand(20);
        send_pkt($urandom, 16'd12, RX_PORT, 16'd28, 1'b0, 1'b0, 7, 1'b0);
        do_reset();
        fill_rand(11);
        send_pkt($urandom, 16'd13, RX_PORT, 16'd19, 1'b0, 1'b0, -1, 1'b0);
        release_buf(0);

        // Packet missing its last beat is aborted by the next first beat.
        fill_rand(12);
        send_pkt($urandom, 16'd14, RX_PORT, 16'd20, 1'b0, 1'b0, 6, 1'b1);
        fill_rand(7);
        send_pkt($urandom, 16'd15, RX_PORT, 16'd15, 1'b0, 1'b0, -1, 1'b1);
        release_buf(0);

        for (int p = 0; p < 30; p++) begin
            n   = ($urandom_range(0, 9) == 0) ? $urandom_range(MAX_BYTES - 8, MAX_BYTES + 8)
                                              : $urandom_range(1, 40);
            zlp = ($urandom_range(0, 7) == 0);
            err = ($urandom_range(0, 5) == 0);
            dp  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : RX_PORT;
            fill_rand(n);
            send_pkt($urandom, 16'($urandom), dp, zlp ? 16'd8 : 16'(n + 8), err, zlp, -1,
                     1'($urandom));
            if (owned) begin
                if ($urandom_range(0, 2) == 0) begin
                    fill_rand($urandom_range(1, 9));
                    send_pkt($urandom, 16'($urandom), RX_PORT, 16'd12, 1'b0, 1'b0, -1, 1'b0);
                end
                release_buf($urandom_range(0, 3));
            end
        end

        repeat (6) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
